// File: rtl/cvw_pkg.sv
// Shared types and helpers for the divide/sqrt control slice.
// Holds the FSM state encoding and the iteration-count helper.
package cvw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fdivsqrt_state_t;

  // Cycles needed to produce DIVb+1 result bits when DIVCOPIES bits are retired per cycle.
  function automatic int fdivsqrtCycles(input int divb, input int copies);
    return (divb + copies) / copies;
  endfunction

endpackage

// File: rtl/openhw_fdivsqrt_itercnt.sv
// Iteration counter for the divide/sqrt recurrence.
// Provides clear, enable and a terminal-count flag.
module openhw_fdivsqrt_itercnt #(
  parameter int CYCLES = 6,
  parameter int CNTW   = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [CNTW-1:0] o_cnt,
  output logic            o_tc
);

  logic [CNTW-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CNTW'(CYCLES - 1));

endmodule

// File: rtl/openhw_fdivsqrt_ctrl.sv
// Control FSM for the radix-2 divide/sqrt unit.
// Sequences the start pulse, the iteration enables and the done handshake; there is no datapath here.
module openhw_fdivsqrt_ctrl
  import cvw_pkg::*;
#(
  parameter int  DIVb      = 11,
  parameter int  DIVCOPIES = 2,
  localparam int CYCLES    = fdivsqrtCycles(DIVb, DIVCOPIES),
  localparam int CNTW      = ($clog2(CYCLES) > 1) ? $clog2(CYCLES) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            FDivStartE,
  input  logic            SqrtE,
  input  logic            SpecialCaseE,
  input  logic            WZeroE,
  input  logic            FlushE,
  input  logic            StallM,
  output logic            IFDivStartE,
  output logic            IterEnE,
  output logic            FDivBusyE,
  output logic            FDivDoneE,
  output logic            SqrtM,
  output logic            SpecialCaseM,
  output logic [CNTW-1:0] CntE
);

  fdivsqrt_state_t r_state;
  fdivsqrt_state_t w_nextState;
  logic            r_sqrt;
  logic            r_special;
  logic            w_start;
  logic            w_iterEn;
  logic            w_leave;
  logic            w_tc;

  // Resetn gating keeps the start pulse quiet while reset is held.
  assign w_start = resetn & FDivStartE & ~FlushE & (r_state == IDLE);
  assign w_leave = w_tc | (WZeroE & ~r_sqrt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_iterEn    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_nextState = SpecialCaseE ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_iterEn = 1'b1;
        if (w_leave) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (!StallM) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (FlushE) begin
      w_nextState = IDLE;
      w_iterEn    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sqrt    <= 1'b0;
      r_special <= 1'b0;
    end else if (w_start) begin
      r_sqrt    <= SqrtE;
      r_special <= SpecialCaseE;
    end
  end

  // The count is held on the exit cycle so it reports the last iteration performed.
  openhw_fdivsqrt_itercnt #(
    .CYCLES(CYCLES),
    .CNTW  (CNTW)
  ) u_itercnt (
    .clk   (clk),
    .resetn(resetn),
    .i_clr (w_start),
    .i_en  (w_iterEn & ~w_leave),
    .o_cnt (CntE),
    .o_tc  (w_tc)
  );

  assign IFDivStartE  = w_start;
  assign IterEnE      = w_iterEn;
  assign FDivBusyE    = (r_state == BUSY) | (w_start & ~SpecialCaseE);
  assign FDivDoneE    = (r_state == DONE);
  assign SqrtM        = r_sqrt;
  assign SpecialCaseM = r_special;

endmodule

// File: tb/tb_openhw_fdivsqrt_ctrl.sv
// Self-checking bench for openhw_fdivsqrt_ctrl with DIVb=11, DIVCOPIES=2 (six iterations per op).
// Directed scenarios followed by randomized ops checked against a cycle-count model.
module tb_openhw_fdivsqrt_ctrl;

  localparam int NCYC = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       FDivStartE = 1'b0, SqrtE = 1'b0, SpecialCaseE = 1'b0;
  logic       WZeroE = 1'b0, FlushE = 1'b0, StallM = 1'b0;
  logic       IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, SqrtM, SpecialCaseM;
  logic [2:0] CntE;

  int errors = 0;
  int checks = 0;

  openhw_fdivsqrt_ctrl #(.DIVb(11), .DIVCOPIES(2)) dut (
    .clk(clk), .resetn(resetn), .FDivStartE(FDivStartE), .SqrtE(SqrtE),
    .SpecialCaseE(SpecialCaseE), .WZeroE(WZeroE), .FlushE(FlushE), .StallM(StallM),
    .IFDivStartE(IFDivStartE), .IterEnE(IterEnE), .FDivBusyE(FDivBusyE),
    .FDivDoneE(FDivDoneE), .SqrtM(SqrtM), .SpecialCaseM(SpecialCaseM), .CntE(CntE)
  );

  always #5 clk = ~clk;

  // Each cycle: inputs driven 1 after posedge, outputs sampled 5 after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    FDivStartE = 0; SqrtE = 0; SpecialCaseE = 0; WZeroE = 0; FlushE = 0; StallM = 0;
  endtask

  task automatic test_reset();
    clearInputs();
    FDivStartE = 1;
    resetn = 0;
    #2;
    checks++; if (IFDivStartE !== 1'b0) begin errors++; $display("[TB] FAIL rst_istart got=%b exp=0", IFDivStartE); end
    checks++; if (IterEnE !== 1'b0) begin errors++; $display("[TB] FAIL rst_iteren got=%b exp=0", IterEnE); end
    checks++; if (FDivBusyE !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", FDivBusyE); end
    checks++; if (FDivDoneE !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got=%b exp=0", FDivDoneE); end
    checks++; if (CntE !== 3'd0) begin errors++; $display("[TB] FAIL rst_cnt got=%0d exp=0", CntE); end
    checks++; if ({SqrtM, SpecialCaseM} !== 2'b00) begin errors++; $display("[TB] FAIL rst_latched got=%b exp=00", {SqrtM, SpecialCaseM}); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (FDivBusyE !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy_held got=%b exp=0", FDivBusyE); end
    FDivStartE = 0;
    @(negedge clk);
    resetn = 1;
    tick();
  endtask

  task automatic test_divide();
    int iterCount = 0;
    clearInputs();
    FDivStartE = 1;
    #4;
    checks++; if (IFDivStartE !== 1'b1) begin errors++; $display("[TB] FAIL div_istart got=%b exp=1", IFDivStartE); end
    checks++; if (FDivBusyE !== 1'b1) begin errors++; $display("[TB] FAIL div_busy0 got=%b exp=1", FDivBusyE); end
    tick();
    FDivStartE = 0;
    for (int c = 1; c <= 8; c++) begin
      #4;
      if (IterEnE === 1'b1) iterCount++;
      checks++; if (IterEnE !== (c <= NCYC)) begin errors++; $display("[TB] FAIL div_iteren c=%0d got=%b exp=%b", c, IterEnE, c <= NCYC); end
      checks++; if (FDivDoneE !== (c == NCYC + 1)) begin errors++; $display("[TB] FAIL div_done c=%0d got=%b exp=%b", c, FDivDoneE, c == NCYC + 1); end
      if (c <= NCYC) begin
        checks++; if (CntE !== 3'(c - 1)) begin errors++; $display("[TB] FAIL div_cnt c=%0d got=%0d exp=%0d", c, CntE, c - 1); end
      end
      tick();
    end
    checks++; if (iterCount != NCYC) begin errors++; $display("[TB] FAIL div_itercount got=%0d exp=%0d", iterCount, NCYC); end
  endtask

  task automatic test_special();
    clearInputs();
    FDivStartE = 1; SpecialCaseE = 1; SqrtE = 1;
    #4;
    checks++; if (IFDivStartE !== 1'b1) begin errors++; $display("[TB] FAIL sp_istart got=%b exp=1", IFDivStartE); end
    checks++; if (FDivBusyE !== 1'b0) begin errors++; $display("[TB] FAIL sp_busy got=%b exp=0", FDivBusyE); end
    tick();
    clearInputs();
    #4;
    checks++; if (FDivDoneE !== 1'b1) begin errors++; $display("[TB] FAIL sp_done got=%b exp=1", FDivDoneE); end
    checks++; if (IterEnE !== 1'b0) begin errors++; $display("[TB] FAIL sp_iteren got=%b exp=0", IterEnE); end
    checks++; if ({SqrtM, SpecialCaseM} !== 2'b11) begin errors++; $display("[TB] FAIL sp_latched got=%b exp=11", {SqrtM, SpecialCaseM}); end
    tick();
    #4;
    checks++; if (FDivDoneE !== 1'b0) begin errors++; $display("[TB] FAIL sp_idle got=%b exp=0", FDivDoneE); end
    tick();
  endtask

  task automatic test_early_term();
    for (int sq = 0; sq < 2; sq++) begin
      int expIters = (sq == 1) ? NCYC : 3;
      int iterCount = 0;
      clearInputs();
      FDivStartE = 1; SqrtE = sq[0];
      tick();
      FDivStartE = 0;
      for (int c = 1; c <= 10; c++) begin
        WZeroE = (c == 3);
        #4;
        if (IterEnE === 1'b1) iterCount++;
        checks++; if (FDivDoneE !== (c == expIters + 1)) begin errors++; $display("[TB] FAIL et_done sq=%0d c=%0d got=%b", sq, c, FDivDoneE); end
        if (c == expIters + 1) begin
          checks++; if (CntE !== 3'(expIters - 1)) begin errors++; $display("[TB] FAIL et_frozen sq=%0d got=%0d exp=%0d", sq, CntE, expIters - 1); end
        end
        tick();
      end
      checks++; if (iterCount != expIters) begin errors++; $display("[TB] FAIL et_itercount sq=%0d got=%0d exp=%0d", sq, iterCount, expIters); end
    end
    clearInputs();
  endtask

  task automatic test_stall();
    int doneCount = 0;
    clearInputs();
    FDivStartE = 1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      FDivStartE = (c >= NCYC + 1);
      StallM     = (c >= NCYC + 1) && (c <= NCYC + 3);
      #4;
      if (FDivDoneE === 1'b1) doneCount++;
      checks++; if (IFDivStartE !== 1'b0) begin errors++; $display("[TB] FAIL st_ignore c=%0d got=%b exp=0", c, IFDivStartE); end
      tick();
    end
    clearInputs();
    #4;
    checks++; if (doneCount != 4) begin errors++; $display("[TB] FAIL st_donecount got=%0d exp=4", doneCount); end
    checks++; if ({FDivBusyE, FDivDoneE} !== 2'b00) begin errors++; $display("[TB] FAIL st_idle got=%b exp=00", {FDivBusyE, FDivDoneE}); end
    tick();
    FDivStartE = 1; SpecialCaseE = 1;
    tick();
    clearInputs();
    StallM = 1; FlushE = 1;
    #4;
    checks++; if (FDivDoneE !== 1'b1) begin errors++; $display("[TB] FAIL st_flushcycle got=%b exp=1", FDivDoneE); end
    tick();
    FlushE = 0;
    #4;
    checks++; if (FDivDoneE !== 1'b0) begin errors++; $display("[TB] FAIL st_flushwins got=%b exp=0", FDivDoneE); end
    tick();
    clearInputs();
  endtask

  task automatic test_flush();
    int iterCount = 0;
    clearInputs();
    FDivStartE = 1; FlushE = 1;
    #4;
    checks++; if ({IFDivStartE, FDivBusyE} !== 2'b00) begin errors++; $display("[TB] FAIL fl_startgate got=%b exp=00", {IFDivStartE, FDivBusyE}); end
    tick();
    clearInputs();
    #4;
    checks++; if (FDivBusyE !== 1'b0) begin errors++; $display("[TB] FAIL fl_notstarted got=%b exp=0", FDivBusyE); end
    tick();
    FDivStartE = 1;
    tick();
    FDivStartE = 0;
    for (int c = 1; c <= 4; c++) begin
      FlushE = (c == 4);
      #4;
      if (c == 4) begin
        checks++; if (CntE !== 3'd3) begin errors++; $display("[TB] FAIL fl_cnt got=%0d exp=3", CntE); end
        checks++; if (IterEnE !== 1'b0) begin errors++; $display("[TB] FAIL fl_itergate got=%b exp=0", IterEnE); end
      end
      tick();
    end
    clearInputs();
    FDivStartE = 1;
    #4;
    checks++; if ({IFDivStartE, FDivDoneE} !== 2'b10) begin errors++; $display("[TB] FAIL fl_restart got=%b exp=10", {IFDivStartE, FDivDoneE}); end
    tick();
    FDivStartE = 0;
    for (int c = 1; c <= 8; c++) begin
      #4;
      if (IterEnE === 1'b1) iterCount++;
      checks++; if (FDivDoneE !== (c == NCYC + 1)) begin errors++; $display("[TB] FAIL fl_done c=%0d got=%b", c, FDivDoneE); end
      tick();
    end
    checks++; if (iterCount != NCYC) begin errors++; $display("[TB] FAIL fl_itercount got=%0d exp=%0d", iterCount, NCYC); end
  endtask

  task automatic test_reset_mid();
    int doneSeen = 0;
    clearInputs();
    FDivStartE = 1; SqrtE = 1;
    tick();
    FDivStartE = 0;
    repeat (4) tick();
    #2;
    checks++; if (CntE !== 3'd4) begin errors++; $display("[TB] FAIL rm_cnt got=%0d exp=4", CntE); end
    resetn = 0;
    #1;
    checks++; if ({IFDivStartE, IterEnE, FDivBusyE, FDivDoneE} !== 4'b0000) begin errors++; $display("[TB] FAIL rm_outs got=%b exp=0000", {IFDivStartE, IterEnE, FDivBusyE, FDivDoneE}); end
    checks++; if ({CntE, SqrtM, SpecialCaseM} !== 5'b0) begin errors++; $display("[TB] FAIL rm_regs got=%b exp=00000", {CntE, SqrtM, SpecialCaseM}); end
    repeat (2) begin
      @(negedge clk);
      if (FDivDoneE === 1'b1) doneSeen++;
    end
    resetn = 1;
    tick();
    checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL rm_nodone got=%0d exp=0", doneSeen); end
    FDivStartE = 1;
    #4;
    checks++; if (IFDivStartE !== 1'b1) begin errors++; $display("[TB] FAIL rm_accept got=%b exp=1", IFDivStartE); end
    tick();
    FDivStartE = 0;
    repeat (NCYC) tick();
    #4;
    checks++; if (FDivDoneE !== 1'b1) begin errors++; $display("[TB] FAIL rm_done got=%b exp=1", FDivDoneE); end
    tick();
    tick();
  endtask

  // Model: an op retires one iteration per cycle; divide stops after the iteration where the
  // remainder is zero, special cases need none; DONE lasts 1 + stall cycles; a flush ends the op.
  task automatic test_random();
    for (int op = 0; op < 30; op++) begin
      int sq = $urandom_range(0, 1);
      int sp = ($urandom_range(0, 3) == 0) ? 1 : 0;
      int wz = $urandom_range(0, 8);
      int stall = $urandom_range(0, 3);
      int iters = (sp == 1) ? 0 : ((sq == 1 || wz >= NCYC) ? NCYC : wz + 1);
      int doneStart = iters + 1;
      int lastCyc = doneStart + stall;
      int flushAt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lastCyc) : 0;
      logic [2:0] expCnt;
      clearInputs();
      FDivStartE = 1; SqrtE = sq[0]; SpecialCaseE = sp[0];
      #4;
      checks++; if (IFDivStartE !== 1'b1) begin errors++; $display("[TB] FAIL rnd_istart op=%0d got=%b exp=1", op, IFDivStartE); end
      checks++; if (FDivBusyE !== (sp == 0)) begin errors++; $display("[TB] FAIL rnd_busy0 op=%0d got=%b exp=%b", op, FDivBusyE, sp == 0); end
      tick();
      for (int c = 1; c <= lastCyc; c++) begin
        FDivStartE   = 1'($urandom_range(0, 1));
        SqrtE        = 1'($urandom_range(0, 1));
        SpecialCaseE = 1'($urandom_range(0, 1));
        WZeroE       = (sq == 1) ? 1'($urandom_range(0, 1)) : (sp == 0 && c == wz + 1);
        StallM       = (c >= doneStart) ? (c < lastCyc) : 1'($urandom_range(0, 1));
        FlushE       = (c == flushAt);
        expCnt       = (c < doneStart) ? 3'(c - 1) : ((sp == 1) ? 3'd0 : 3'(iters - 1));
        #4;
        checks++; if (IFDivStartE !== 1'b0) begin errors++; $display("[TB] FAIL rnd_istart_busy op=%0d c=%0d got=%b exp=0", op, c, IFDivStartE); end
        checks++; if (IterEnE !== (c < doneStart && c != flushAt)) begin errors++; $display("[TB] FAIL rnd_iteren op=%0d c=%0d got=%b", op, c, IterEnE); end
        checks++; if (FDivDoneE !== (c >= doneStart)) begin errors++; $display("[TB] FAIL rnd_done op=%0d c=%0d got=%b exp=%b", op, c, FDivDoneE, c >= doneStart); end
        checks++; if (FDivBusyE !== (c < doneStart)) begin errors++; $display("[TB] FAIL rnd_busy op=%0d c=%0d got=%b exp=%b", op, c, FDivBusyE, c < doneStart); end
        checks++; if (CntE !== expCnt) begin errors++; $display("[TB] FAIL rnd_cnt op=%0d c=%0d got=%0d exp=%0d", op, c, CntE, expCnt); end
        checks++; if ({SqrtM, SpecialCaseM} !== {sq[0], sp[0]}) begin errors++; $display("[TB] FAIL rnd_latched op=%0d got=%b exp=%b", op, {SqrtM, SpecialCaseM}, {sq[0], sp[0]}); end
        tick();
        if (c == flushAt) break;
      end
      if (flushAt != 0) begin
        clearInputs();
        #4;
        checks++; if ({FDivBusyE, FDivDoneE, IterEnE} !== 3'b000) begin errors++; $display("[TB] FAIL rnd_flushidle op=%0d got=%b exp=000", op, {FDivBusyE, FDivDoneE, IterEnE}); end
        tick();
      end
    end
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_divide();
    test_special();
    test_early_term();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/openhw_fdivsqrt_ctrl.md
OPENHW_FDIVSQRT_CTRL -- requirements
Module: openhw_fdivsqrt_ctrl

Interface
REQ-001 SHALL have parameter DIVb, default 11: quotient/root fraction bits beyond the integer bit.
REQ-002 SHALL have parameter DIVCOPIES, default 2: radix-2 stages chained per cycle, legal values 1, 2, 4.
REQ-003 SHALL derive localparam CYCLES = ceil((DIVb+1)/DIVCOPIES) and localparam CNTW = max(1, clog2(CYCLES)).
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port FDivStartE, input, 1: operation request, sampled only in IDLE.
REQ-007 SHALL have port SqrtE, input, 1: 1 = sqrt, 0 = divide; valid with FDivStartE.
REQ-008 SHALL have port SpecialCaseE, input, 1: zero/inf/NaN operand, so no iterations are needed.
REQ-009 SHALL have port WZeroE, input, 1: partial remainder WS+WC is zero this cycle.
REQ-010 SHALL have port FlushE, input, 1: pipeline flush, aborts any operation.
REQ-011 SHALL have port StallM, input, 1: downstream stall, holds the result.
REQ-012 SHALL have port IFDivStartE, output, 1: one-cycle pulse that loads the initial WS/WC/U/UM/C registers.
REQ-013 SHALL have port IterEnE, output, 1: enables the iteration registers to capture the recurrence outputs.
REQ-014 SHALL have port FDivBusyE, output, 1: stalls the pipeline front end.
REQ-015 SHALL have port FDivDoneE, output, 1: result valid.
REQ-016 SHALL have port SqrtM, output, 1: the latched operation type.
REQ-017 SHALL have port SpecialCaseM, output, 1: the latched special-case flag.
REQ-018 SHALL have port CntE, output, CNTW: current iteration index.

Function
REQ-019 SHALL implement an FSM with the states IDLE, BUSY and DONE.
REQ-020 IDLE: when FDivStartE & ~FlushE, SHALL assert IFDivStartE combinationally, latch SqrtE/SpecialCaseE into SqrtM/SpecialCaseM, and clear CntE to 0.
REQ-021 IDLE -> DONE when the start is accepted and SpecialCaseE=1; IDLE -> BUSY when the start is accepted and SpecialCaseE=0.
REQ-022 BUSY: SHALL assert IterEnE and increment CntE by 1 each cycle.
REQ-023 BUSY -> DONE when CntE == CYCLES-1, or when WZeroE & ~SqrtM (divide early termination); CntE SHALL freeze on leaving BUSY.
REQ-024 DONE: SHALL assert FDivDoneE; stay in DONE while StallM=1; go to IDLE when StallM=0.
REQ-025 FDivBusyE SHALL equal (state==BUSY) | (IFDivStartE & ~SpecialCaseE).
REQ-026 FDivStartE outside IDLE SHALL be ignored; a start in the DONE->IDLE cycle is not accepted.
REQ-027 FlushE in any state: next state SHALL be IDLE; IFDivStartE and IterEnE SHALL be gated low in the flush cycle.
REQ-028 FlushE together with StallM in DONE SHALL resolve as flush wins.
REQ-029 Latency, start at cycle 0: normal op gives DONE at cycle CYCLES+1; special case gives DONE at cycle 1.
REQ-030 IterEnE SHALL be asserted exactly CYCLES times per unflushed, non-terminated op.

Reset
REQ-031 resetn=0 SHALL asynchronously force state IDLE, CntE=0, SqrtM=0 and SpecialCaseM=0.
REQ-032 During reset, IFDivStartE, IterEnE, FDivBusyE and FDivDoneE SHALL all be 0.
REQ-033 Reset mid-operation SHALL abandon the operation with no done pulse.
REQ-034 Release of reset SHALL be synchronized externally; the first active edge after release is treated as IDLE.

Structure
REQ-035 The state enum type fdivsqrt_state_t and the CYCLES computation function SHALL live in the shared cvw package.
REQ-036 The iteration counter (clear, enable, terminal-count compare) SHALL be one sub-module, openhw_fdivsqrt_itercnt.
REQ-037 The block SHALL contain no datapath; it drives enables for the radix-2 stage registers only.

Verification (DIVb=11, DIVCOPIES=2, so CYCLES=6)
REQ-038 Divide, start at cycle 0, no WZeroE -> IFDivStartE at 0; IterEnE at cycles 1-6, CntE 0..5; FDivDoneE at 7; IDLE at 8.
REQ-039 SpecialCaseE=1 with start -> FDivBusyE=0, no IterEnE, FDivDoneE at cycle 1, SpecialCaseM=1.
REQ-040 Divide, WZeroE=1 at CntE=2 -> DONE next cycle with CntE frozen at 2; the same stimulus with SqrtE=1 runs the full 6 iterations.
REQ-041 StallM=1 for 3 cycles in DONE -> FDivDoneE held 4 cycles, and a concurrent FDivStartE is ignored.
REQ-042 FlushE at CntE=3 -> IDLE next cycle, no FDivDoneE; a new start the following cycle completes normally.
REQ-043 resetn low at CntE=4 -> all outputs 0 immediately; after release, the FSM is in IDLE and accepts a new start.
